// File: rtl/mdu_pkg.sv
// Shared opcode encodings, FSM states and default latencies for the E-stage MDU.
// Defining MDU_MADD_EN makes opcode 1001 (madd) a launch operation.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  function automatic logic is_launch_op(input logic [3:0] op);
    logic hit;
    hit = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
    hit = hit || (op == MDU_MADD);
`endif
    return hit;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with HI/LO registers and mfhi/mflo read port.
// Optional madd (opcode 1001) is compiled in when MDU_MADD_EN is defined.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDU_Ctr,
  input  logic        Start,
  input  logic        E_Is_New,
  output logic        Busy,
  output logic [31:0] MDU_Result
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot_s, rem_s, quot_u, rem_u;

  // Datapath works on latched operands only; results are consumed at the final busy edge.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    if (b_q != '0) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      // Most-negative / -1 overflows; the wrapped quotient equals the dividend.
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quot_s = a_q;
        rem_s  = '0;
      end else begin
        quot_s = $signed(a_q) / $signed(b_q);
        rem_s  = $signed(a_q) % $signed(b_q);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (E_Is_New) begin
          if (Start && is_launch_op(MDU_Ctr)) begin
            state_d = ST_BUSY;
            op_d    = mdu_op_e'(MDU_Ctr);
            a_d     = SrcA;
            b_d     = SrcB;
            cnt_d   = is_div_op(MDU_Ctr) ? DIV_CYCLES : MULT_CYCLES;
          end else if (MDU_Ctr == MDU_MTHI) begin
            hi_d = SrcA;
          end else if (MDU_Ctr == MDU_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 32'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          case (op_q)
            MDU_MULT:  {hi_d, lo_d} = prod_s;
            MDU_MULTU: {hi_d, lo_d} = prod_u;
            MDU_DIV: begin
              if (b_q != '0) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            MDU_DIVU: begin
              if (b_q != '0) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_NONE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == ST_BUSY);

  always_comb begin
    MDU_Result = '0;
    if (MDU_Ctr == MDU_MFHI) begin
      MDU_Result = hi_q;
    end else if (MDU_Ctr == MDU_MFLO) begin
      MDU_Result = lo_q;
    end
  end

endmodule
